cpu_host: RTL and testbench
===========================

# cpu_host

Host-side controller for the robin CPU: the counterpart of the CPU's memory-initiator and halt/halted interface. It takes command bytes from a UART byte stream and acts on them. It loads program bytes into the shared memory and reads memory back. It starts the CPU at a chosen address and waits for the CPU to halt, by instruction or on request, then streams the CPU's 64-byte register dump back over the transmit byte stream. It sits between the UART and the memory/CPU pair and owns the memory port whenever the CPU is held in reset.

## Interface
- addr_width, 9, memory address width; must match the CPU's address width.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  command/data byte from the UART receiver.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  host accepts a byte; a transfer happens on a cycle where rx_valid & rx_ready.
- tx_data  out  8  reply byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid; held with tx_data stable until tx_ready.
- tx_ready  in  1  transmitter accepts a byte; a transfer happens on a cycle where tx_valid & tx_ready.
- mem_raddr  out  addr_width  memory read address (host side of the memory-port mux).
- mem_waddr  out  addr_width  memory write address.
- mem_data_in  out  8  write data to memory.
- mem_data_out  in  8  read data from memory.
- mem_write  out  1  one-cycle write strobe.
- mem_owner  out  1  1 = host drives the memory port; 0 = CPU drives it.
- cpu_reset  out  1  CPU reset.
- cpu_halt  out  1  CPU halt request.
- cpu_halted  in  1  CPU has finished its register dump.
- start_address  out  addr_width  CPU start address; sampled by the CPU while cpu_reset is high.

## Operation

**Reset values**
- mem_owner=1, cpu_reset=1.
- All other outputs 0.
- State IDLE.

**Commands.** Multi-byte arguments are received big-endian. Addresses use the low addr_width bits of the 16-bit argument. Lengths are 16-bit.

- **0x01 LOAD a16 n16 d[n]**
  - Writes d[i] to address (a+i) mod 2^addr_width.
  - Replies 0x01 after the last write.
  - n=0: replies 0x01 immediately after the 5 header bytes.
- **0x02 READ a16 n16**
  - Replies n bytes, mem[(a+i) mod 2^addr_width].
  - n=0: no reply.
- **0x03 RUN a16**
  - Sets start_address=a, then drops cpu_reset and mem_owner on the same cycle.
  - Enters RUNWAIT, where only 0x04 is accepted.
  - When cpu_halted=1: reasserts cpu_reset and mem_owner, clears cpu_halt, replies 0x03, then sends 64 bytes mem[2..65] (registers r0..r15, big-endian).
- **0x04 STOP**
  - In RUNWAIT: sets cpu_halt=1, held until cpu_halted; completion then proceeds exactly as for RUN.
  - In IDLE: replies 0x04 only.
- **Any other byte in IDLE:** replies 0xFF.

**States**
- IDLE → ARGS, collecting 2 or 4 argument bytes with a down-counter.
- From ARGS, per command:
  - LOAD: LDATA ↔ LWRITE, then REPLY.
  - READ: RADDR → RWAIT → RCAP → RSEND, looping per byte.
  - RUN: RUNWAIT → REPLY → DUMP (reuses RADDR/RWAIT/RCAP/RSEND with base 2, count 64).
- All paths return to IDLE.

**rx_ready**
- 1 in IDLE, ARGS and LDATA.
- In RUNWAIT: 1, but any byte other than 0x04 is discarded.
- 0 elsewhere.

**Boundary conditions**
- Address increments wrap modulo 2^addr_width; the byte counter is 16 bits.
- cpu_halted and rx_valid high in the same RUNWAIT cycle: halted wins and the byte is not accepted (rx_ready=0 that cycle).
- Reset mid-operation aborts immediately to the reset values. Memory bytes already written stay written; a partial reply is not completed.
- The host must not assert mem_write while mem_owner=0.

## Timing
- **Write:**
  - Data byte accepted on cycle t.
  - On t+1: mem_waddr and mem_data_in are valid and mem_write=1; rx_ready=0.
  - rx_ready=1 again on t+2.
  - Sustained rate: 1 byte per 2 cycles.
- **Read:**
  - mem_raddr is registered on cycle t (RADDR); RWAIT is cycle t+1.
  - mem_data_out is sampled into tx_data at the t+2 edge (RCAP), matching the memory's 2-cycle read.
  - tx_valid is asserted the cycle after capture and held until tx_ready.
- **RUN:** cpu_reset falls 1 cycle after the second address byte is accepted.
- **Halt detection:** cpu_halted is sampled every cycle in RUNWAIT; cpu_reset rises on the next cycle.
- **Reply bytes:** one per accepted tx handshake; no gap is required between them.

## Structure
- Package robin_host_pkg:
  - opcode constants CMD_LOAD=1, CMD_READ=2, CMD_RUN=3, CMD_STOP=4, REPLY_ERR=8'hFF;
  - DUMP_BASE=2, DUMP_LEN=64;
  - the state enum.
- Single module, no sub-module. The memory-port mux is selected by mem_owner and lives in the top level, outside this block.

## Test plan
- LOAD 0x01 00 10 00 03 AA BB CC → mem[0x10..0x12]=AA,BB,CC; reply 0x01; each mem_write exactly 1 cycle; rx_ready low on each write cycle.
- READ at 0x1FE, n=4 with preloaded data → replies mem[0x1FE], mem[0x1FF], mem[0x000], mem[0x001] (address wrap); tx_ready stalled 5 cycles mid-stream → tx_data stays stable.
- LOAD a program ending in 0xFFFF, then RUN 0x0004 → start_address=4 while cpu_reset falls; on cpu_halted: 0x03 followed by 64 bytes, where bytes 4..7 = 00 00 00 01 (r1) and r15 equals the halt PC.
- RUN of an infinite loop, then STOP → cpu_halt=1 until cpu_halted; reply 0x03 plus 64 dump bytes; a stray 0x55 during RUNWAIT is discarded.
- Unknown byte 0x7E → reply 0xFF; LOAD with n=0 → reply 0x01 with no mem_write.
- reset asserted mid-LOAD after 1 of 3 data bytes → outputs at reset values (mem_owner=1, cpu_reset=1, tx_valid=0); first byte kept in memory; next command is parsed normally.

Source files
------------

// File: rtl/robin_host_pkg.sv
// Shared constants for the robin host controller: command opcodes, register-dump window and FSM states.
// Pure declarations, no logic.
package robin_host_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_STOP  = 8'h04;
  localparam logic [7:0] REPLY_ERR = 8'hFF;

  localparam int DUMP_BASE = 2;
  localparam int DUMP_LEN  = 64;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARGS,
    S_LDATA,
    S_LWRITE,
    S_RADDR,
    S_RWAIT,
    S_RCAP,
    S_RSEND,
    S_RUNWAIT,
    S_REPLY
  } state_e;

endpackage

// File: rtl/cpu_host.sv
// UART-driven host for the robin CPU: loads/reads memory, runs the CPU and returns its register dump.
// Writes take 2 cycles per byte, reads 4 cycles per byte plus tx stall; rx_ready drops whenever a byte cannot be taken.
module cpu_host
  import robin_host_pkg::*;
#(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out,
  output logic                  mem_write,
  output logic                  mem_owner,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic [addr_width-1:0] start_address
);

  state_e                state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [1:0]            argcnt_q, argcnt_d;
  logic [23:0]           args_q, args_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [addr_width-1:0] mem_raddr_q, mem_raddr_d;
  logic [addr_width-1:0] mem_waddr_q, mem_waddr_d;
  logic [7:0]            mem_data_in_q, mem_data_in_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_owner_q, mem_owner_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_halt_q, cpu_halt_d;
  logic [addr_width-1:0] start_address_q, start_address_d;

  logic        rx_fire;
  logic        tx_fire;
  logic [31:0] arg_word;

  // A halt seen in RUNWAIT takes priority over any byte offered that cycle.
  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE, S_ARGS, S_LDATA: rx_ready = 1'b1;
      S_RUNWAIT:               rx_ready = ~cpu_halted;
      default:                 rx_ready = 1'b0;
    endcase
  end

  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid_q & tx_ready;
  assign arg_word = {args_q, rx_data};

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    argcnt_d        = argcnt_q;
    args_d          = args_q;
    addr_d          = addr_q;
    len_d           = len_q;
    tx_data_d       = tx_data_q;
    tx_valid_d      = tx_valid_q;
    mem_raddr_d     = mem_raddr_q;
    mem_waddr_d     = mem_waddr_q;
    mem_data_in_d   = mem_data_in_q;
    mem_write_d     = 1'b0;
    mem_owner_d     = mem_owner_q;
    cpu_reset_d     = cpu_reset_q;
    cpu_halt_d      = cpu_halt_q;
    start_address_d = start_address_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          cmd_d = rx_data;
          case (rx_data)
            CMD_LOAD, CMD_READ: begin argcnt_d = 2'd3; state_d = S_ARGS; end
            CMD_RUN:            begin argcnt_d = 2'd1; state_d = S_ARGS; end
            CMD_STOP:           begin tx_data_d = CMD_STOP;  tx_valid_d = 1'b1; state_d = S_REPLY; end
            default:            begin tx_data_d = REPLY_ERR; tx_valid_d = 1'b1; state_d = S_REPLY; end
          endcase
        end
      end
      S_ARGS: begin
        if (rx_fire) begin
          args_d   = arg_word[23:0];
          argcnt_d = argcnt_q - 2'd1;
          if (argcnt_q == 2'd0) begin
            if (cmd_q == CMD_RUN) begin
              start_address_d = addr_width'(arg_word[15:0]);
              cpu_reset_d     = 1'b0;
              mem_owner_d     = 1'b0;
              state_d         = S_RUNWAIT;
            end else begin
              addr_d = addr_width'(arg_word[31:16]);
              len_d  = arg_word[15:0];
              if (arg_word[15:0] == 16'd0) begin
                if (cmd_q == CMD_LOAD) begin
                  tx_data_d  = CMD_LOAD;
                  tx_valid_d = 1'b1;
                  state_d    = S_REPLY;
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                state_d = (cmd_q == CMD_LOAD) ? S_LDATA : S_RADDR;
              end
            end
          end
        end
      end
      S_LDATA: begin
        if (rx_fire) begin
          mem_waddr_d   = addr_q;
          mem_data_in_d = rx_data;
          mem_write_d   = 1'b1;
          state_d       = S_LWRITE;
        end
      end
      S_LWRITE: begin
        addr_d = addr_q + addr_width'(1);
        len_d  = len_q - 16'd1;
        if (len_q == 16'd1) begin
          tx_data_d  = CMD_LOAD;
          tx_valid_d = 1'b1;
          state_d    = S_REPLY;
        end else begin
          state_d = S_LDATA;
        end
      end
      S_RADDR: begin
        mem_raddr_d = addr_q;
        state_d     = S_RWAIT;
      end
      S_RWAIT: state_d = S_RCAP;
      // Memory returns data two cycles after the registered address.
      S_RCAP: begin
        tx_data_d  = mem_data_out;
        tx_valid_d = 1'b1;
        state_d    = S_RSEND;
      end
      S_RSEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          addr_d     = addr_q + addr_width'(1);
          len_d      = len_q - 16'd1;
          state_d    = (len_q == 16'd1) ? S_IDLE : S_RADDR;
        end
      end
      S_RUNWAIT: begin
        if (cpu_halted) begin
          cpu_reset_d = 1'b1;
          mem_owner_d = 1'b1;
          cpu_halt_d  = 1'b0;
          tx_data_d   = CMD_RUN;
          tx_valid_d  = 1'b1;
          state_d     = S_REPLY;
        end else if (rx_fire && rx_data == CMD_STOP) begin
          cpu_halt_d = 1'b1;
        end
      end
      S_REPLY: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (cmd_q == CMD_RUN) begin
            addr_d  = addr_width'(DUMP_BASE);
            len_d   = 16'(DUMP_LEN);
            state_d = S_RADDR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cmd_q           <= '0;
      argcnt_q        <= '0;
      args_q          <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      tx_data_q       <= '0;
      tx_valid_q      <= 1'b0;
      mem_raddr_q     <= '0;
      mem_waddr_q     <= '0;
      mem_data_in_q   <= '0;
      mem_write_q     <= 1'b0;
      mem_owner_q     <= 1'b1;
      cpu_reset_q     <= 1'b1;
      cpu_halt_q      <= 1'b0;
      start_address_q <= '0;
    end else begin
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      argcnt_q        <= argcnt_d;
      args_q          <= args_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      tx_data_q       <= tx_data_d;
      tx_valid_q      <= tx_valid_d;
      mem_raddr_q     <= mem_raddr_d;
      mem_waddr_q     <= mem_waddr_d;
      mem_data_in_q   <= mem_data_in_d;
      mem_write_q     <= mem_write_d;
      mem_owner_q     <= mem_owner_d;
      cpu_reset_q     <= cpu_reset_d;
      cpu_halt_q      <= cpu_halt_d;
      start_address_q <= start_address_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign mem_raddr     = mem_raddr_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_data_in   = mem_data_in_q;
  assign mem_write     = mem_write_q;
  assign mem_owner     = mem_owner_q;
  assign cpu_reset     = cpu_reset_q;
  assign cpu_halt      = cpu_halt_q;
  assign start_address = start_address_q;

endmodule

// File: tb/tb_cpu_host.sv
// Bench for cpu_host: behavioural memory + stub CPU around the DUT, scoreboard queues for tx bytes and memory writes.
module tb_cpu_host;
  import robin_host_pkg::*;

  localparam int AW    = 9;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] mem_raddr, mem_waddr, start_address;
  logic [7:0]    mem_data_in, mem_data_out;
  logic          mem_write, mem_owner, cpu_reset, cpu_halt, cpu_halted;

  always #5 clk = ~clk;

  cpu_host #(.addr_width(AW)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_write(mem_write), .mem_owner(mem_owner),
    .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .cpu_halted(cpu_halted),
    .start_address(start_address)
  );

  // Environment memory (host/CPU port mux) and the reference image the bench reasons about.
  logic [7:0]    mem     [MEMSZ];
  logic [7:0]    ref_mem [MEMSZ];
  logic          init_pending = 1'b1;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_waddr = '0;
  logic [7:0]    cpu_wdata = '0;

  always @(posedge clk) begin
    if (init_pending) begin
      for (int i = 0; i < MEMSZ; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mem_write) mem[mem_waddr] <= mem_data_in;
      if (!mem_owner && cpu_we) mem[cpu_waddr] <= cpu_wdata;
    end
    mem_data_out <= mem[mem_raddr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int tx_count = 0;
  int writes_seen = 0;
  int stall_cnt = 0;
  logic [7:0]      exp_q[$];
  logic [AW+7:0]   wq[$];
  logic [7:0]      payload[$];
  logic [31:0]     regs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected event expected normal completion", name);
  endtask

  // Monitor: drives tx_ready, checks every tx handshake and every memory write against the queues.
  logic       held = 1'b0;
  logic [7:0] held_data = '0;
  logic       prev_w = 1'b0;
  logic [AW+7:0] we;
  logic [7:0]    te;
  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      tx_ready = 1'b0;
      stall_cnt--;
    end else begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end
    if (reset) begin
      held = 1'b0;
      prev_w = 1'b0;
    end else begin
      if (held) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, held_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) fail("tx_extra_byte");
        else begin
          te = exp_q.pop_front();
          chk("tx_byte", tx_data, te);
        end
        tx_count++;
        held = 1'b0;
      end else if (tx_valid) begin
        held = 1'b1;
        held_data = tx_data;
      end else begin
        held = 1'b0;
      end
      if (mem_write) begin
        writes_seen++;
        chk("write_owner", mem_owner, 1);
        chk("write_rx_ready_low", rx_ready, 0);
        chk("write_single_cycle", prev_w, 0);
        if (wq.size() == 0) fail("write_unexpected");
        else begin
          we = wq.pop_front();
          chk("write_addr", mem_waddr, we[AW+7:8]);
          chk("write_data", mem_data_in, we[7:0]);
        end
      end
      prev_w = mem_write;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) fail("rx_accept_timeout");
    else @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] a, input int n_send);
    int n;
    logic [AW-1:0] ad;
    n = payload.size();
    send_byte(CMD_LOAD); send_byte(a[15:8]); send_byte(a[7:0]);
    send_byte(8'(n >> 8));
    if (n == 0) exp_q.push_back(CMD_LOAD);
    send_byte(8'(n));
    for (int i = 0; i < n_send; i++) begin
      ad = AW'(32'(a) + i);
      wq.push_back({ad, payload[i]});
      ref_mem[ad] = payload[i];
      if (i == n - 1) exp_q.push_back(CMD_LOAD);
      send_byte(payload[i]);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[AW'(32'(a) + i)]);
    send_byte(CMD_READ); send_byte(a[15:8]); send_byte(a[7:0]);
    send_byte(8'(n >> 8)); send_byte(8'(n));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || wq.size() != 0) fail("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  // Stub CPU: writes regs[] as the big-endian dump at mem[2..65], then raises cpu_halted.
  task automatic do_run(input logic [15:0] a, input bit stop_mode);
    logic [7:0] b;
    int t;
    exp_q.push_back(CMD_RUN);
    for (int i = 0; i < DUMP_LEN; i++) begin
      b = 8'(regs[i / 4] >> (8 * (3 - (i % 4))));
      exp_q.push_back(b);
      ref_mem[DUMP_BASE + i] = b;
    end
    send_byte(CMD_RUN); send_byte(a[15:8]); send_byte(a[7:0]);
    @(negedge clk);
    chk("run_cpu_reset_low", cpu_reset, 0);
    chk("run_mem_owner_low", mem_owner, 0);
    chk("run_start_address", start_address, 32'(a) % MEMSZ);
    if (stop_mode) begin
      repeat ($urandom_range(3, 10)) @(negedge clk);
      send_byte(8'h55);
      @(negedge clk);
      chk("stray_no_halt", cpu_halt, 0);
      chk("stray_still_running", cpu_reset, 0);
      send_byte(CMD_STOP);
      @(negedge clk);
      chk("stop_halt_req", cpu_halt, 1);
      t = 0;
      repeat ($urandom_range(2, 6)) begin
        @(negedge clk);
        chk("stop_halt_held", cpu_halt, 1);
      end
    end else begin
      repeat ($urandom_range(5, 20)) @(negedge clk);
    end
    for (int i = 0; i < DUMP_LEN; i++) begin
      @(negedge clk);
      cpu_we = 1'b1;
      cpu_waddr = AW'(DUMP_BASE + i);
      cpu_wdata = ref_mem[DUMP_BASE + i];
    end
    @(negedge clk);
    cpu_we = 1'b0;
    cpu_halted = 1'b1;
    if (stop_mode) chk("halt_req_until_halted", cpu_halt, 1);
    else begin
      rx_data = CMD_STOP;
      rx_valid = 1'b1;
      chk("halted_beats_rx", rx_ready, 0);
    end
    @(negedge clk);
    chk("halt_cpu_reset_high", cpu_reset, 1);
    chk("halt_mem_owner_high", mem_owner, 1);
    chk("halt_req_cleared", cpu_halt, 0);
    rx_valid = 1'b0;
    cpu_halted = 1'b0;
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t, w0, op;
    logic [15:0] ra;
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'($urandom);
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    cpu_halted = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    init_pending = 1'b0;
    chk("rst_mem_owner", mem_owner, 1);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_cpu_halt", cpu_halt, 0);
    chk("rst_start_address", start_address, 0);
    chk("rst_rx_ready", rx_ready, 1);
    reset = 1'b0;

    payload = '{8'hAA, 8'hBB, 8'hCC};
    do_load(16'h0010, 3);
    wait_drain();
    chk("load_mem10", mem[9'h010], 8'hAA);
    chk("load_mem12", mem[9'h012], 8'hCC);

    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(16'h01FE, 4);
    wait_drain();
    c0 = tx_count;
    do_read(16'h01FE, 4);
    t = 0;
    while (!(tx_count >= c0 + 2 && tx_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) fail("read_stall_setup");
    else stall_cnt = 5;
    wait_drain();

    payload = '{8'h12, 8'h34, 8'hFF, 8'hFF};
    do_load(16'h0004, 4);
    wait_drain();
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[1] = 32'd1;
    regs[15] = 32'd6;
    do_run(16'h0004, 1'b0);

    payload = '{8'h80, 8'h00};
    do_load(16'h0040, 2);
    wait_drain();
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[15] = 32'h40;
    do_run(16'hFE40, 1'b1);

    exp_q.push_back(REPLY_ERR);
    send_byte(8'h7E);
    wait_drain();
    exp_q.push_back(CMD_STOP);
    send_byte(CMD_STOP);
    wait_drain();
    w0 = writes_seen;
    payload = {};
    do_load(16'h0100, 0);
    wait_drain();
    chk("load_n0_no_write", writes_seen, w0);

    repeat (20) begin
      op = $urandom_range(0, 3);
      ra = 16'($urandom);
      case (op)
        0: begin
          payload = {};
          repeat ($urandom_range(0, 5)) payload.push_back(8'($urandom));
          do_load(ra, payload.size());
        end
        1: do_read(ra, $urandom_range(0, 5));
        2: begin
          exp_q.push_back(REPLY_ERR);
          send_byte(8'($urandom_range(5, 255)));
        end
        default: begin
          exp_q.push_back(CMD_STOP);
          send_byte(CMD_STOP);
        end
      endcase
      wait_drain();
    end

    payload = '{8'h5A, 8'h6B, 8'h7C};
    do_load(16'h0120, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_mem_owner", mem_owner, 1);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_mem_write", mem_write, 0);
    reset = 1'b0;
    wq.delete();
    chk("midrst_first_byte_kept", mem[9'h120], 8'h5A);
    do_read(16'h0120, 3);
    wait_drain();

    chk("final_tx_queue_empty", exp_q.size(), 0);
    chk("final_write_queue_empty", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
